io_bus_responder: RTL

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_bus_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/io_bus_responder.sv
// io_bus_responder: single-cycle-latency CPU bus slave exposing an LED
// register, debounced switch status, a free-running cycle counter and a
// sticky switch-change flag.
module io_bus_responder #(
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  sw,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [7:0]  led
);

    localparam logic [5:0] ADDR_LED  = 6'h20;
    localparam logic [5:0] ADDR_SW   = 6'h21;
    localparam logic [5:0] ADDR_CYC  = 6'h22;
    localparam logic [5:0] ADDR_FLAG = 6'h23;
    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        take;
    logic        wr_led;
    logic        wr_cyc;
    logic        clr_flag;
    logic        db_done;
    logic [31:0] rd_mux;
    logic [1:0]  sw_meta;
    logic [1:0]  sw_sync;
    logic [1:0]  sw_stable;
    logic [7:0]  db_cnt;
    logic        chg_flag;
    logic [31:0] cyc_cnt;
    logic        unused_wdata;

    // Only the LED byte and the flag-clear bit of the write data are used.
    assign unused_wdata = ^wdata[31:8];

    // A request is taken only from IDLE; the RESP cycle ignores req.
    assign wr_led   = take & we & (addr == ADDR_LED);
    assign wr_cyc   = take & we & (addr == ADDR_CYC);
    assign clr_flag = take & we & (addr == ADDR_FLAG) & wdata[0];
    assign db_done  = (sw_sync != sw_stable) && (db_cnt == DB_LAST);

    // Bus FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bus FSM next state; ack is high for the whole RESP cycle.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    take      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ack       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read decode from register values as they stand before the sampling edge.
    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            ADDR_LED:  rd_mux = {24'h0, led};
            ADDR_SW:   rd_mux = {30'h0, sw_stable};
            ADDR_CYC:  rd_mux = cyc_cnt;
            ADDR_FLAG: rd_mux = {31'h0, chg_flag};
            default:   rd_mux = 32'h0;
        endcase
    end

    // Read data is captured on the sampling edge and zero in every other cycle.
    always_ff @(posedge clk) begin
        if (rst)             rdata <= 32'h0;
        else if (take && !we) rdata <= rd_mux;
        else                 rdata <= 32'h0;
    end

    // LED register drives the board pins directly.
    always_ff @(posedge clk) begin
        if (rst)         led <= 8'h00;
        else if (wr_led) led <= wdata[7:0];
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 2'b00;
            sw_sync <= 2'b00;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Debounce: accept a new switch value once it has differed for DEBOUNCE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= 8'h00;
            sw_stable <= 2'b00;
        end else if (sw_sync == sw_stable) begin
            db_cnt    <= 8'h00;
        end else if (db_done) begin
            db_cnt    <= 8'h00;
            sw_stable <= sw_sync;
        end else begin
            db_cnt    <= db_cnt + 8'h01;
        end
    end

    // Sticky change flag; a debounce completion beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst)           chg_flag <= 1'b0;
        else if (db_done)  chg_flag <= 1'b1;
        else if (clr_flag) chg_flag <= 1'b0;
    end

    // Free-running cycle counter; a write clears it in place of the increment.
    always_ff @(posedge clk) begin
        if (rst)         cyc_cnt <= 32'h0;
        else if (wr_cyc) cyc_cnt <= 32'h0;
        else             cyc_cnt <= cyc_cnt + 32'h1;
    end

endmodule
